// File: rtl/bus_transfer_sequencer_if.sv
// Signal bundle between the control unit / shared register bus and the bus transfer sequencer.
interface bus_transfer_sequencer_if #(
  parameter int unsigned N_REGS = 4,
  parameter int unsigned IDX_W  = 2
);
  logic              req;
  logic [IDX_W-1:0]  src;
  logic [IDX_W-1:0]  dst;
  logic              imm_en;
  logic [7:0]        imm;
  logic [7:0]        bus_in;
  logic [N_REGS-1:0] OE;
  logic [N_REGS-1:0] WE;
  logic [7:0]        bus_out;
  logic              bus_drive;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        last_data;

  modport master (
    output req, src, dst, imm_en, imm, bus_in,
    input  OE, WE, bus_out, bus_drive, busy, done, err, last_data
  );

  modport slave (
    input  req, src, dst, imm_en, imm, bus_in,
    output OE, WE, bus_out, bus_drive, busy, done, err, last_data
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Bus initiator: sequences per-register OE/WE strobes for one register or immediate transfer at a time
// and captures the transferred byte.
module bus_transfer_sequencer #(
  parameter int unsigned N_REGS = 4,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  bus_transfer_sequencer_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam logic [IDX_W:0]    REG_LIMIT   = (IDX_W + 1)'(N_REGS);
  localparam logic [N_REGS-1:0] ONE_HOT_LSB = N_REGS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  src;
    logic [IDX_W-1:0]  dst;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
    logic              rej;
  } xfer_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  xfer_t             xfer_q, xfer_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic [N_REGS-1:0] oe_q, oe_d;
  logic [N_REGS-1:0] we_q, we_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              bus_drive_q, bus_drive_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req_bad_c;
  logic              src_en_c;

  // Request rejected on out-of-range index or a register copied onto itself
  assign req_bad_c = ({1'b0, bus.dst} >= REG_LIMIT) ||
                     (!bus.imm_en && (({1'b0, bus.src} >= REG_LIMIT) || (bus.src == bus.dst)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xfer_d      = xfer_q;
    last_data_d = last_data_q;
    src_en_c    = 1'b0;
    oe_d        = '0;
    we_d        = '0;
    bus_out_d   = '0;
    bus_drive_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          xfer_d = '{src: bus.src, dst: bus.dst, imm_en: bus.imm_en, imm: bus.imm, rej: req_bad_c};
          if (req_bad_c) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = CNT_W'(SETTLE - 1);
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WRITE: begin
        last_data_d = bus.bus_in;
        state_d     = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    src_en_c = (state_d == ST_DRIVE) || (state_d == ST_WRITE);
    if (src_en_c && xfer_d.imm_en) begin
      bus_drive_d = 1'b1;
      bus_out_d   = xfer_d.imm;
    end
    if (src_en_c && !xfer_d.imm_en) begin
      oe_d = ONE_HOT_LSB << xfer_d.src;
    end
    if (state_d == ST_WRITE) begin
      we_d = ONE_HOT_LSB << xfer_d.dst;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    err_d  = done_d && xfer_d.rej;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      xfer_q      <= '0;
      last_data_q <= '0;
      oe_q        <= '0;
      we_q        <= '0;
      bus_out_q   <= '0;
      bus_drive_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xfer_q      <= xfer_d;
      last_data_q <= last_data_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      bus_out_q   <= bus_out_d;
      bus_drive_q <= bus_drive_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.OE        = oe_q;
  assign bus.WE        = we_q;
  assign bus.bus_out   = bus_out_q;
  assign bus.bus_drive = bus_drive_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.last_data = last_data_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: two instances (SETTLE=1 with 3-bit indices, SETTLE=3 with 2-bit
// indices) share one stimulus stream and are checked every cycle against a timeline model.
module tb_bus_transfer_sequencer;

  localparam int unsigned N_REGS   = 4;
  localparam int unsigned IDX_W_A  = 3;
  localparam int unsigned IDX_W_B  = 2;
  localparam int unsigned SETTLE_A = 1;
  localparam int unsigned SETTLE_B = 3;
  localparam int          N_VEC    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bus_transfer_sequencer_if #(.N_REGS(N_REGS), .IDX_W(IDX_W_A)) ifa ();
  bus_transfer_sequencer_if #(.N_REGS(N_REGS), .IDX_W(IDX_W_B)) ifb ();

  bus_transfer_sequencer #(.N_REGS(N_REGS), .IDX_W(IDX_W_A), .SETTLE(SETTLE_A)) u_dut_a (
    .CLK(clk), .RESET_n(rst_n), .bus(ifa)
  );
  bus_transfer_sequencer #(.N_REGS(N_REGS), .IDX_W(IDX_W_B), .SETTLE(SETTLE_B)) u_dut_b (
    .CLK(clk), .RESET_n(rst_n), .bus(ifb)
  );

  logic       req_v;
  logic [2:0] src_v;
  logic [2:0] dst_v;
  logic       imm_en_v;
  logic [7:0] imm_v;
  logic [7:0] reg_val [N_REGS];

  assign ifa.req    = req_v;
  assign ifa.src    = src_v;
  assign ifa.dst    = dst_v;
  assign ifa.imm_en = imm_en_v;
  assign ifa.imm    = imm_v;
  assign ifb.req    = req_v;
  assign ifb.src    = src_v[1:0];
  assign ifb.dst    = dst_v[1:0];
  assign ifb.imm_en = imm_en_v;
  assign ifb.imm    = imm_v;

  // Shared bus: the enabled register, else the initiator's drive, else a floating marker value
  function automatic logic [7:0] bus_value(logic [3:0] oe, logic drv, logic [7:0] bo);
    logic [7:0] v;
    v = 8'hEE;
    if (drv) v = bo;
    for (int i = 0; i < 4; i++) if (oe[i]) v = reg_val[i];
    return v;
  endfunction

  assign ifa.bus_in = bus_value(ifa.OE, ifa.bus_drive, ifa.bus_out);
  assign ifb.bus_in = bus_value(ifb.OE, ifb.bus_drive, ifb.bus_out);

  typedef struct packed {
    logic [3:0] oe;
    logic [3:0] we;
    logic       drv;
    logic [7:0] bo;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] last;
  } outs_t;

  typedef struct {
    logic [2:0] src;
    logic [2:0] dst;
    logic       imm_en;
    logic [7:0] imm;
    logic [3:0] oe;
    logic [3:0] we;
    int         src_cyc;
    logic       drv;
    int         done_at;
    logic       err;
    logic [7:0] last;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Transfer timeline model: one record per instance, outputs derived from cycle offset since accept
  logic       m_act    [2];
  int         m_start  [2];
  logic [2:0] m_src    [2];
  logic [2:0] m_dst    [2];
  logic       m_imm_en [2];
  logic [7:0] m_imm    [2];
  logic       m_bad    [2];
  logic [7:0] m_last   [2];
  int         settle_k [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k]  = 1'b0;
      m_last[k] = 8'h00;
    end
  endtask

  task automatic model_edge(int k);
    int off;
    logic [2:0] s;
    logic [2:0] d;
    s = (k == 0) ? src_v : {1'b0, src_v[1:0]};
    d = (k == 0) ? dst_v : {1'b0, dst_v[1:0]};
    if (m_act[k]) begin
      off = cyc - m_start[k];
      if (m_bad[k]) begin
        if (off >= 1) m_act[k] = 1'b0;
      end else begin
        if (off == settle_k[k] + 1) m_last[k] = m_imm_en[k] ? m_imm[k] : reg_val[m_src[k][1:0]];
        if (off >= settle_k[k] + 2) m_act[k] = 1'b0;
      end
    end else if (req_v) begin
      m_act[k]    = 1'b1;
      m_start[k]  = cyc;
      m_src[k]    = s;
      m_dst[k]    = d;
      m_imm_en[k] = imm_en_v;
      m_imm[k]    = imm_v;
      m_bad[k]    = (d >= 3'd4) || (!imm_en_v && ((s >= 3'd4) || (s == d)));
    end
  endtask

  function automatic outs_t expected(int k);
    outs_t e;
    int off;
    e = '0;
    e.last = m_last[k];
    if (m_act[k]) begin
      off = cyc - m_start[k];
      e.busy = 1'b1;
      if (m_bad[k]) begin
        e.done = 1'b1;
        e.err  = 1'b1;
      end else begin
        if (off <= settle_k[k]) begin
          if (m_imm_en[k]) begin
            e.drv = 1'b1;
            e.bo  = m_imm[k];
          end else begin
            e.oe = 4'(1) << m_src[k];
          end
        end
        if (off == settle_k[k]) e.we = 4'(1) << m_dst[k];
        if (off == settle_k[k] + 1) e.done = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic outs_t observed(int k);
    outs_t o;
    if (k == 0) o = '{oe: ifa.OE, we: ifa.WE, drv: ifa.bus_drive, bo: ifa.bus_out, busy: ifa.busy,
                      done: ifa.done, err: ifa.err, last: ifa.last_data};
    else        o = '{oe: ifb.OE, we: ifb.WE, drv: ifb.bus_drive, bo: ifb.bus_out, busy: ifb.busy,
                      done: ifb.done, err: ifb.err, last: ifb.last_data};
    return o;
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("oe=%b we=%b drv=%b bo=%h busy=%b done=%b err=%b last=%h",
                     o.oe, o.we, o.drv, o.bo, o.busy, o.done, o.err, o.last);
  endfunction

  task automatic check_inst(int k, string tag);
    outs_t e;
    outs_t o;
    e = expected(k);
    o = observed(k);
    if (!e.drv) begin
      o.bo = '0;
      e.bo = '0;
    end
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got: %s | want: %s", tag, k, cyc, fmt(o), fmt(e));
    end
  endtask

  task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // One clock: model sees the same inputs the DUTs sampled, outputs compared 1 unit after the edge
  task automatic tick(string tag);
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check_inst(0, tag);
    check_inst(1, tag);
  endtask

  vec_t vecs [N_VEC];

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int         done_at, src_cyc, done_p, rise_p, oe_b, we_b, we_p;
    logic [3:0] oe_or, we_or;
    logic       drv_seen, err_seen;
    logic [7:0] bo_seen;

    vecs[0] = '{3'd0, 3'd1, 1'b0, 8'h00, 4'b0001, 4'b0010, 2, 1'b0, 2, 1'b0, 8'h5A};
    vecs[1] = '{3'd3, 3'd2, 1'b1, 8'hC3, 4'b0000, 4'b0100, 2, 1'b1, 2, 1'b0, 8'hC3};
    vecs[2] = '{3'd3, 3'd3, 1'b0, 8'h00, 4'b0000, 4'b0000, 0, 1'b0, 0, 1'b1, 8'hC3};
    vecs[3] = '{3'd1, 3'd4, 1'b0, 8'h00, 4'b0000, 4'b0000, 0, 1'b0, 0, 1'b1, 8'hC3};
    vecs[4] = '{3'd5, 3'd0, 1'b0, 8'h00, 4'b0000, 4'b0000, 0, 1'b0, 0, 1'b1, 8'hC3};
    vecs[5] = '{3'd3, 3'd0, 1'b0, 8'h00, 4'b1000, 4'b0001, 2, 1'b0, 2, 1'b0, 8'hA7};
    vecs[6] = '{3'd7, 3'd3, 1'b1, 8'h00, 4'b0000, 4'b1000, 2, 1'b1, 2, 1'b0, 8'h00};
    vecs[7] = '{3'd2, 3'd1, 1'b0, 8'h00, 4'b0100, 4'b0010, 2, 1'b0, 2, 1'b0, 8'h96};
    vecs[8] = '{3'd6, 3'd0, 1'b1, 8'hFF, 4'b0000, 4'b0001, 2, 1'b1, 2, 1'b0, 8'hFF};
    vecs[9] = '{3'd0, 3'd5, 1'b1, 8'h11, 4'b0000, 4'b0000, 0, 1'b0, 0, 1'b1, 8'hFF};

    reg_val[0] = 8'h5A;
    reg_val[1] = 8'h3C;
    reg_val[2] = 8'h96;
    reg_val[3] = 8'hA7;
    settle_k[0] = int'(SETTLE_A);
    settle_k[1] = int'(SETTLE_B);
    req_v = 1'b0; src_v = '0; dst_v = '0; imm_en_v = 1'b0; imm_v = '0;
    model_reset();

    // Reset pulse mid-cycle, then idle
    #2 rst_n = 1'b0;
    #1;
    check_inst(0, "reset");
    check_inst(1, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick("idle");

    // Table-driven single transfers on the SETTLE=1 instance
    for (int v = 0; v < N_VEC; v++) begin
      req_v = 1'b1; src_v = vecs[v].src; dst_v = vecs[v].dst;
      imm_en_v = vecs[v].imm_en; imm_v = vecs[v].imm;
      oe_or = '0; we_or = '0; src_cyc = 0; drv_seen = 1'b0; bo_seen = '0;
      err_seen = 1'b0; done_at = -1;
      tick("vec");
      req_v = 1'b0;
      for (int i = 0; i < 8 && done_at < 0; i++) begin
        if (i > 0) tick("vec");
        oe_or = oe_or | ifa.OE;
        we_or = we_or | ifa.WE;
        if ((ifa.OE != '0) || ifa.bus_drive) src_cyc++;
        if (ifa.bus_drive) begin
          drv_seen = 1'b1;
          bo_seen  = ifa.bus_out;
        end
        if (ifa.done) begin
          done_at  = i;
          err_seen = ifa.err;
        end
      end
      tick("vec");
      cmp($sformatf("vec%0d_oe", v), 32'(oe_or), 32'(vecs[v].oe));
      cmp($sformatf("vec%0d_we", v), 32'(we_or), 32'(vecs[v].we));
      cmp($sformatf("vec%0d_src_cycles", v), 32'(src_cyc), 32'(vecs[v].src_cyc));
      cmp($sformatf("vec%0d_drive", v), 32'(drv_seen), 32'(vecs[v].drv));
      cmp($sformatf("vec%0d_done_at", v), 32'(done_at), 32'(vecs[v].done_at));
      cmp($sformatf("vec%0d_err", v), 32'(err_seen), 32'(vecs[v].err));
      cmp($sformatf("vec%0d_last", v), 32'(ifa.last_data), 32'(vecs[v].last));
      if (vecs[v].drv) cmp($sformatf("vec%0d_bus_out", v), 32'(bo_seen), 32'(vecs[v].imm));
    end

    // req held high with fields changing every cycle
    repeat (8) tick("idle");
    req_v = 1'b1; imm_en_v = 1'b0; src_v = 3'd0; dst_v = 3'd1;
    done_p = -1; rise_p = -1; oe_b = 0; we_b = 0; we_p = -1;
    for (int p = 0; p < 16; p++) begin
      tick("b2b");
      if (p < 5) begin
        if (ifb.OE != '0) oe_b++;
        if (ifb.WE != '0) begin
          we_b++;
          we_p = p;
        end
      end
      if (ifa.done && (done_p < 0)) done_p = p;
      if ((done_p >= 0) && (rise_p < 0) && (p > done_p) && (ifa.OE != '0)) rise_p = p;
      src_v = 3'($urandom_range(0, 3));
      dst_v = 3'((32'(src_v) + 32'd1 + $urandom_range(0, 2)) % 32'd4);
    end
    req_v = 1'b0;
    cmp("b2b_restart_gap", 32'(rise_p - done_p), 32'd2);
    cmp("s3_oe_cycles", 32'(oe_b), 32'd4);
    cmp("s3_we_cycles", 32'(we_b), 32'd1);
    cmp("s3_we_position", 32'(we_p), 32'd3);

    // Randomized traffic
    repeat (8) tick("idle");
    for (int n = 0; n < 400; n++) begin
      req_v    = ($urandom_range(0, 2) != 0);
      src_v    = 3'($urandom_range(0, 4));
      dst_v    = 3'($urandom_range(0, 4));
      imm_en_v = $urandom_range(0, 2) == 0;
      imm_v    = 8'($urandom);
      tick("rand");
    end
    req_v = 1'b0;

    // Reset asserted during WRITE of the SETTLE=1 instance
    repeat (8) tick("pre_rst");
    req_v = 1'b1; src_v = 3'd1; dst_v = 3'd2; imm_en_v = 1'b0;
    tick("rst_req");
    req_v = 1'b0;
    tick("rst_write");
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_async_oe_a", 32'(ifa.OE), 32'd0);
    cmp("rst_async_we_a", 32'(ifa.WE), 32'd0);
    cmp("rst_async_oe_b", 32'(ifb.OE), 32'd0);
    cmp("rst_async_busy_a", 32'(ifa.busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick("post_rst");
    cmp("post_rst_last_a", 32'(ifa.last_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
